// File: rtl/ccu_pkg.sv
// Shared definitions for the condition-code / arithmetic-trap unit.
// Latency: n/a (constants, types and one helper only).
// Backpressure: n/a.
package ccu_pkg;

  // cc_ctrl_h function codes; codes not listed here are no-ops
  localparam logic [3:0] CC_FLUSH   = 4'h1;
  localparam logic [3:0] CC_ATCR_RD = 4'h2;
  localparam logic [3:0] CC_PSL_RD  = 4'h3;
  localparam logic [3:0] CC_PSL_WR  = 4'h9;
  localparam logic [3:0] CC_CC_WR   = 4'hA;
  localparam logic [3:0] CC_PSW_WR  = 4'hB;
  localparam logic [3:0] CC_OP1     = 4'hC;
  localparam logic [3:0] CC_OP2     = 4'hE;
  localparam logic [3:0] CC_SET_V   = 4'hF;

  // Arithmetic trap codes
  localparam logic [3:0] TRAP_INT_OVF  = 4'd1;
  localparam logic [3:0] TRAP_DIV_ZERO = 4'd2;
  localparam logic [3:0] TRAP_DEC_OVF  = 4'd6;

  // Opcode classes
  localparam logic [1:0] CLS_INT = 2'd1;
  localparam logic [1:0] CLS_DEC = 2'd2;
  localparam logic [1:0] CLS_DIV = 2'd3;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_WORD = 2'd1,
    SZ_LONG = 2'd2,
    SZ_QUAD = 2'd3
  } size_e;

  typedef struct packed {
    logic n;
    logic z;
    logic v;
    logic c;
  } cc_t;

  // Codes that update V and may therefore raise an arithmetic trap
  function automatic logic is_trap_src(input logic [3:0] code);
    return (code == CC_CC_WR) || (code == CC_OP1) ||
           (code == CC_OP2)   || (code == CC_SET_V);
  endfunction

endpackage

// File: rtl/trap_fifo.sv
// Pending arithmetic-trap queue: power-of-2 deep FIFO with sticky overflow.
// Latency: push visible at head one cycle after the push edge; flush/pop take effect at the edge.
// Backpressure: none; push while full is dropped and sets ovf_o (unless a pop frees the slot).
// Ports: clk_i/rst_ni (sync, active-low), push_i/push_dat_i, pop_i, flush_i,
//        full_o, empty_o, head_dat_o, ovf_o.
module trap_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 4
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         push_i,
  input  logic [W-1:0] push_dat_i,
  input  logic         pop_i,
  input  logic         flush_i,
  output logic         full_o,
  output logic         empty_o,
  output logic [W-1:0] head_dat_o,
  output logic         ovf_o
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wr_ptr_q, wr_ptr_d;
  logic [AW:0]  rd_ptr_q, rd_ptr_d;
  logic         ovf_q, ovf_d;
  logic         do_push, do_pop;

  // Extra pointer MSB distinguishes full from empty
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  // Flush wins over everything; a pop in the same cycle frees a slot for a push into a full queue
  assign do_pop  = pop_i && !empty_o && !flush_i;
  assign do_push = push_i && (!full_o || do_pop) && !flush_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    ovf_d    = ovf_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      ovf_d    = 1'b0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (push_i && !do_push) ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage needs no reset: empty_o gates the head everywhere it is used
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_dat_i;
  end

  assign head_dat_o = mem_q[rd_ptr_q[AW-1:0]];
  assign ovf_o      = ovf_q;

endmodule

// File: rtl/cc_trap_unit.sv
// Condition-code register, PSL trap enables and queued arithmetic-trap reporting.
// Latency: CC/enables update at the edge; a qualifying trap reaches the queue one edge later.
// Backpressure: none; traps beyond TQ_DEPTH are dropped and flagged on trap_ovf_h.
// Ports: b_clk_l, reset_l (sync, active-low), d_clk_en_h cycle enable; cc_ctrl_h/d_size_h/
//        op_class_h + ALU result flags in; wbus_out_h read-back, pslc_h, ccbr_h, trap status out.
module cc_trap_unit
  import ccu_pkg::*;
#(
  parameter int DW       = 32,
  parameter int TQ_DEPTH = 4
) (
  input  logic            b_clk_l,
  input  logic            reset_l,
  input  logic            d_clk_en_h,
  input  logic [3:0]      cc_ctrl_h,
  input  logic [1:0]      d_size_h,
  input  logic [1:0]      op_class_h,
  input  logic [DW-1:0]   wbus_h,
  input  logic [DW/8-1:0] wmuxz_h,
  input  logic [3:0]      aluv_h,
  input  logic [3:0]      aluc_l,
  input  logic            divz_h,
  input  logic            trap_ack_h,
  output logic [7:0]      wbus_out_h,
  output logic            pslc_h,
  output logic [1:0]      ccbr_h,
  output logic            arith_trap_l,
  output logic [3:0]      trap_code_h,
  output logic            trap_ovf_h
);
  size_e      size_eff;
  cc_t        live_cc;
  cc_t        cc_q, cc_d;
  logic       dv_q, dv_d, fu_q, fu_d, iv_q, iv_d, comp_q, comp_d;
  logic       pend_vld_q, pend_vld_d;
  logic [3:0] pend_code_q, pend_code_d;
  logic       fifo_full, fifo_empty, fifo_ovf;
  logic [3:0] fifo_head;
  logic       unused_ok;

  // Flags of the current ALU result; a 32-bit datapath has no quad, so quad reads as long
  always_comb begin
    size_eff = size_e'(d_size_h);
    if ((DW == 32) && (size_eff == SZ_QUAD)) size_eff = SZ_LONG;
    live_cc.v = aluv_h[size_eff];
    live_cc.c = ~aluc_l[size_eff];
    case (size_eff)
      SZ_BYTE: begin live_cc.n = wbus_h[7];    live_cc.z = wmuxz_h[0];      end
      SZ_WORD: begin live_cc.n = wbus_h[15];   live_cc.z = &wmuxz_h[1:0];   end
      SZ_LONG: begin live_cc.n = wbus_h[31];   live_cc.z = &wmuxz_h[3:0];   end
      default: begin live_cc.n = wbus_h[DW-1]; live_cc.z = &wmuxz_h;        end
    endcase
  end

  always_comb begin
    cc_d        = cc_q;
    dv_d        = dv_q;
    fu_d        = fu_q;
    iv_d        = iv_q;
    comp_d      = comp_q;
    pend_vld_d  = 1'b0;
    pend_code_d = 4'd0;
    case (cc_ctrl_h)
      CC_PSL_WR: begin
        cc_d   = cc_t'(wbus_h[3:0]);
        dv_d   = wbus_h[7];
        fu_d   = wbus_h[6];
        iv_d   = wbus_h[5];
        comp_d = wbus_h[DW-1];
      end
      CC_PSW_WR: begin
        cc_d = cc_t'(wbus_h[3:0]);
        dv_d = wbus_h[7];
        fu_d = wbus_h[6];
        iv_d = wbus_h[5];
      end
      CC_CC_WR: cc_d = cc_t'(wbus_h[3:0]);
      CC_OP1:   cc_d = live_cc;
      CC_OP2:   cc_d = '{n: live_cc.n, z: live_cc.z, v: live_cc.v, c: cc_q.c};
      CC_SET_V: cc_d.v = 1'b1;
      default: ;
    endcase
    // Trap qualification looks at the V being written this cycle; the enables
    // are not modified by any trap-source code, so their current value applies.
    if (is_trap_src(cc_ctrl_h) && !comp_q) begin
      if ((op_class_h == CLS_INT) && cc_d.v && iv_q) begin
        pend_vld_d  = 1'b1;
        pend_code_d = TRAP_INT_OVF;
      end else if ((op_class_h == CLS_DEC) && cc_d.v && dv_q) begin
        pend_vld_d  = 1'b1;
        pend_code_d = TRAP_DEC_OVF;
      end else if ((op_class_h == CLS_DIV) && divz_h) begin
        pend_vld_d  = 1'b1;
        pend_code_d = TRAP_DIV_ZERO;
      end
    end
  end

  always_ff @(posedge b_clk_l) begin
    if (!reset_l) begin
      cc_q        <= '0;
      dv_q        <= 1'b0;
      fu_q        <= 1'b0;
      iv_q        <= 1'b0;
      comp_q      <= 1'b0;
      pend_vld_q  <= 1'b0;
      pend_code_q <= 4'd0;
    end else if (d_clk_en_h) begin
      cc_q        <= cc_d;
      dv_q        <= dv_d;
      fu_q        <= fu_d;
      iv_q        <= iv_d;
      comp_q      <= comp_d;
      pend_vld_q  <= pend_vld_d;
      pend_code_q <= pend_code_d;
    end
  end

  trap_fifo #(
    .DEPTH (TQ_DEPTH),
    .W     (4)
  ) u_trap_fifo (
    .clk_i      (b_clk_l),
    .rst_ni     (reset_l),
    .push_i     (pend_vld_q && d_clk_en_h),
    .push_dat_i (pend_code_q),
    .pop_i      (trap_ack_h && d_clk_en_h),
    .flush_i    (d_clk_en_h && (cc_ctrl_h == CC_FLUSH)),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .head_dat_o (fifo_head),
    .ovf_o      (fifo_ovf)
  );

  assign arith_trap_l = fifo_empty;
  assign trap_code_h  = fifo_empty ? 4'd0 : fifo_head;
  assign trap_ovf_h   = fifo_ovf;
  assign pslc_h       = cc_q.c;

  always_comb begin
    case (cc_ctrl_h)
      CC_PSL_RD:  wbus_out_h = {dv_q, fu_q, iv_q, 1'b0, cc_q};
      CC_ATCR_RD: wbus_out_h = {fifo_ovf, 3'b000, trap_code_h};
      default:    wbus_out_h = 8'hFF;
    endcase
  end

  // Branch condition tracks the result being produced on arithmetic codes
  always_comb begin
    if ((cc_ctrl_h == 4'h0) || (cc_ctrl_h == CC_OP1) || (cc_ctrl_h == CC_OP2))
      ccbr_h = {live_cc.n ^ live_cc.v, live_cc.z};
    else
      ccbr_h = {cc_q.n ^ cc_q.v, cc_q.z};
  end

  // Most write-bus bits are intentionally ignored
  assign unused_ok = ^{wbus_h, fifo_full};

endmodule

// File: tb/tb_cc_trap_unit.sv
// Bench for cc_trap_unit: DW=32 and DW=64 instances share one stimulus stream.
// Latency: n/a.
// Backpressure: n/a.
module tb_cc_trap_unit;
  import ccu_pkg::*;

  logic        clk = 1'b0;
  logic        reset_l, en, divz, ack;
  logic [3:0]  cc_ctrl, aluv, aluc_l;
  logic [1:0]  size, cls;
  logic [63:0] wbus;
  logic [7:0]  wmuxz;

  logic [7:0]  wout32, wout64;
  logic        pslc32, pslc64, trap_l32, trap_l64, tovf32, tovf64;
  logic [1:0]  ccbr32, ccbr64;
  logic [3:0]  tcode32, tcode64;

  int          checks = 0;
  int          failures = 0;
  logic [3:0]  exp_q[$];
  logic        exp_ovf = 1'b0;

  always #5 clk = ~clk;

  cc_trap_unit #(.DW(32), .TQ_DEPTH(4)) u_dut32 (
    .b_clk_l(clk), .reset_l(reset_l), .d_clk_en_h(en), .cc_ctrl_h(cc_ctrl),
    .d_size_h(size), .op_class_h(cls), .wbus_h(wbus[31:0]), .wmuxz_h(wmuxz[3:0]),
    .aluv_h(aluv), .aluc_l(aluc_l), .divz_h(divz), .trap_ack_h(ack),
    .wbus_out_h(wout32), .pslc_h(pslc32), .ccbr_h(ccbr32), .arith_trap_l(trap_l32),
    .trap_code_h(tcode32), .trap_ovf_h(tovf32)
  );

  cc_trap_unit #(.DW(64), .TQ_DEPTH(4)) u_dut64 (
    .b_clk_l(clk), .reset_l(reset_l), .d_clk_en_h(en), .cc_ctrl_h(cc_ctrl),
    .d_size_h(size), .op_class_h(cls), .wbus_h(wbus), .wmuxz_h(wmuxz),
    .aluv_h(aluv), .aluc_l(aluc_l), .divz_h(divz), .trap_ack_h(ack),
    .wbus_out_h(wout64), .pslc_h(pslc64), .ccbr_h(ccbr64), .arith_trap_l(trap_l64),
    .trap_code_h(tcode64), .trap_ovf_h(tovf64)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cc_ctrl = 4'h0;
    cls     = 2'd0;
    divz    = 1'b0;
    ack     = 1'b0;
  endtask

  // Scoreboard model of the 4-deep trap queue
  task automatic sb_push(input logic [3:0] code);
    if (exp_q.size() < 4) exp_q.push_back(code);
    else exp_ovf = 1'b1;
  endtask

  // Compare the head the DUT is presenting while an ack is driven, then retire it
  task automatic sb_pop(input string tag);
    if (exp_q.size() == 0) chk(tag, tcode32, 32'd0);
    else begin
      chk(tag, tcode32, exp_q[0]);
      exp_q.delete(0);
    end
  endtask

  // One arithmetic op (code C, long size, V set on all sizes) of the given class
  task automatic trap_op(input logic [1:0] c);
    cc_ctrl = CC_OP1; size = 2'd2; cls = c; aluv = 4'hF; aluc_l = 4'hF;
    divz = (c == CLS_DIV); wbus = 64'd0; wmuxz = 8'h00;
    cyc();
  endtask

  initial begin
    reset_l = 1'b0; en = 1'b1; size = 2'd0; aluv = 4'h0; aluc_l = 4'hF;
    wbus = 64'd0; wmuxz = 8'h00;
    idle();
    cc_ctrl = CC_PSL_RD;
    cyc(); cyc();
    chk("rst_psl", wout32, 8'h00);
    chk("rst_trap_l", trap_l32, 1'b1);
    chk("rst_code", tcode32, 4'd0);
    chk("rst_ovf", tovf32, 1'b0);
    chk("rst_pslc", pslc32, 1'b0);
    reset_l = 1'b1;
    idle(); cyc();

    // Byte op: N from bit 7, V from aluv[0]
    cc_ctrl = CC_OP1; size = 2'd0; wbus = 64'h80; wmuxz = 8'h00; aluv = 4'h1; aluc_l = 4'hF;
    #1 chk("op1_ccbr_live", ccbr32, 2'b00);
    cyc();
    cc_ctrl = CC_PSL_RD; aluv = 4'h0;
    #1 chk("op1_cc", wout32, 8'h0A);
    chk("op1_pslc", pslc32, 1'b0);
    chk("ccbr_from_cc", ccbr32, 2'b00);
    cc_ctrl = CC_OP1;
    #1 chk("ccbr_live_nv", ccbr32, 2'b10);

    // Zero result with carry
    wbus = 64'h0; wmuxz = 8'h01; aluc_l = 4'hE;
    #1 chk("ccbr_live_z", ccbr32, 2'b01);
    cyc();
    cc_ctrl = CC_PSL_RD;
    #1 chk("op1_zc", wout32, 8'h05);
    chk("op1_pslc1", pslc32, 1'b1);

    // op2 keeps C, set-V keeps N/Z/C
    cc_ctrl = CC_OP2; wbus = 64'h80; wmuxz = 8'h00; aluv = 4'h0; aluc_l = 4'hF;
    cyc();
    cc_ctrl = CC_SET_V;
    cyc();
    cc_ctrl = CC_PSL_RD;
    #1 chk("op2_setv", wout32, 8'h0B);

    // Cycle enable low freezes state
    en = 1'b0; cc_ctrl = CC_CC_WR; wbus = 64'h4;
    cyc();
    en = 1'b1; cc_ctrl = CC_PSL_RD;
    #1 chk("en_low", wout32, 8'h0B);

    // IV enable via PSW write, then integer overflow trap
    cc_ctrl = CC_PSW_WR; wbus = 64'h20;
    cyc();
    cc_ctrl = CC_PSL_RD;
    #1 chk("psw_iv", wout32, 8'h20);
    cc_ctrl = CC_OP1; cls = CLS_INT; size = 2'd2; aluv = 4'h4; wbus = 64'h0; wmuxz = 8'h00;
    cyc();
    chk("trap_delay", trap_l32, 1'b1);
    sb_push(TRAP_INT_OVF);
    idle();
    cyc();
    chk("trap_pend", trap_l32, 1'b0);
    chk("trap_code", tcode32, TRAP_INT_OVF);
    cc_ctrl = CC_ATCR_RD;
    #1 chk("atcr_one", wout32, 8'h01);
    idle(); ack = 1'b1;
    sb_pop("ack_head");
    cyc();
    ack = 1'b0;
    chk("ack_empty", trap_l32, 1'b1);

    // COMP suppresses even divide-by-zero
    cc_ctrl = CC_PSL_WR; wbus = 64'h8000_0000_8000_00A0;
    cyc();
    cc_ctrl = CC_OP2; cls = CLS_DIV; divz = 1'b1; size = 2'd2; aluv = 4'hF;
    cyc();
    idle();
    cyc();
    chk("comp_nopush", trap_l32, 1'b1);
    cc_ctrl = CC_PSL_WR; wbus = 64'h0000_0000_0000_00A0;
    cyc();
    cc_ctrl = CC_PSL_RD;
    #1 chk("psl_dv_iv", wout32, 8'hA0);

    // Five traps into a 4-deep queue
    trap_op(CLS_INT); sb_push(TRAP_INT_OVF);
    trap_op(CLS_DEC); sb_push(TRAP_DEC_OVF);
    trap_op(CLS_DIV); sb_push(TRAP_DIV_ZERO);
    trap_op(CLS_DEC); sb_push(TRAP_DEC_OVF);
    trap_op(CLS_DIV); sb_push(TRAP_DIV_ZERO);
    idle();
    cyc();
    chk("ovf_set", tovf32, exp_ovf);
    cc_ctrl = CC_ATCR_RD;
    #1 chk("atcr_ovf", wout32, {exp_ovf, 3'b000, exp_q[0]});
    cc_ctrl = CC_FLUSH;
    cyc();
    exp_q.delete(); exp_ovf = 1'b0;
    idle();
    chk("flush_empty", trap_l32, 1'b1);
    chk("flush_ovf", tovf32, exp_ovf);
    chk("flush_code", tcode32, 4'd0);

    // Flush beats a same-edge push and ack
    trap_op(CLS_INT);
    cc_ctrl = CC_FLUSH; cls = 2'd0; divz = 1'b0; ack = 1'b1;
    cyc();
    idle();
    chk("flush_over_push", trap_l32, 1'b1);

    // Full queue: push with simultaneous ack keeps four entries
    trap_op(CLS_DIV); sb_push(TRAP_DIV_ZERO);
    trap_op(CLS_DEC); sb_push(TRAP_DEC_OVF);
    trap_op(CLS_INT); sb_push(TRAP_INT_OVF);
    trap_op(CLS_DIV); sb_push(TRAP_DIV_ZERO);
    idle();
    cyc();
    chk("full_no_ovf", tovf32, 1'b0);
    trap_op(CLS_DEC);
    idle(); ack = 1'b1;
    sb_pop("full_ack");
    sb_push(TRAP_DEC_OVF);
    cyc();
    chk("full_pushack_ovf", tovf32, exp_ovf);
    for (int i = 0; i < 4; i++) begin
      sb_pop("drain");
      cyc();
    end
    ack = 1'b0;
    chk("drained", trap_l32, 1'b1);

    // Quad size: 64-bit uses bit 63/aluv[3], 32-bit falls back to long
    cc_ctrl = CC_OP1; size = 2'd3; wbus = 64'h8000_0000_0000_0000; wmuxz = 8'hFF;
    aluv = 4'b0100; aluc_l = 4'hF;
    cyc();
    cc_ctrl = CC_PSL_RD;
    #1 chk("quad64_cc", wout64, 8'hAC);
    chk("quad32_cc", wout32, 8'hA6);
    chk("quad64_ccbr", ccbr64, 2'b11);

    // Reset with a queued and a pending trap
    trap_op(CLS_INT);
    idle();
    cyc();
    chk("pre_rst_trap", trap_l32, 1'b0);
    trap_op(CLS_INT);
    reset_l = 1'b0; idle(); cc_ctrl = CC_PSL_RD;
    cyc();
    chk("mid_rst_psl32", wout32, 8'h00);
    chk("mid_rst_psl64", wout64, 8'h00);
    chk("mid_rst_trap32", trap_l32, 1'b1);
    chk("mid_rst_trap64", trap_l64, 1'b1);
    chk("mid_rst_code64", tcode64, 4'd0);
    chk("mid_rst_ovf64", tovf64, 1'b0);
    chk("mid_rst_pslc64", pslc64, 1'b0);
    chk("mid_rst_ccbr64", ccbr64, 2'b00);
    reset_l = 1'b1; cc_ctrl = 4'h0;
    cyc();
    chk("pend_discard", trap_l32, 1'b1);
    chk("pend_discard64", trap_l64, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
